// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage indices, FSM encoding and flush constant for pipeline_ctrl
package pipe_pkg;

    localparam int NUM_STG = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_e;

    // Everything downstream of the PC register is squashed on an exception.
    localparam logic [NUM_STG-1:0] FLUSH_ALL  = 6'b111110;
    localparam logic [NUM_STG-1:0] STALL_NONE = 6'b000000;
    localparam logic [NUM_STG-1:0] STALL_PC   = 6'b000001;

    // Mask with every stage up to and including stg held.
    function automatic logic [NUM_STG-1:0] stall_upto(input int stg);
        logic [NUM_STG-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STG; i++) begin
            if (i <= stg) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/stall_decode.sv
// rtl/stall_decode.sv - priority encoder from per-stage stall requests to a monotone stall mask
module stall_decode
    import pipe_pkg::*;
(
    input  logic               req_if,
    input  logic               req_id,
    input  logic               req_ex,
    input  logic               req_mem,
    output logic [NUM_STG-1:0] stall_mask
);

    // The furthest-downstream requester wins; holding a stage also holds everything before it.
    always_comb begin
        stall_mask = STALL_NONE;
        if (req_mem) begin
            stall_mask = stall_upto(STG_MEM);
        end else if (req_ex) begin
            stall_mask = stall_upto(STG_EX);
        end else if (req_id) begin
            stall_mask = stall_upto(STG_ID);
        end else if (req_if) begin
            stall_mask = stall_upto(STG_IF);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush generator with exception redirect sequencing
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_if,
    input  logic               req_id,
    input  logic               req_ex,
    input  logic               req_mem,
    input  logic               if_busy,
    input  logic               exc_valid,
    input  logic [ADDR_W-1:0]  exc_target,
    output logic [NUM_STG-1:0] stall,
    output logic [NUM_STG-1:0] flush,
    output logic               pc_redirect_valid,
    output logic [ADDR_W-1:0]  pc_redirect_target,
    output logic               fetch_discard,
    output logic [CNT_W-1:0]   stall_cycles
);

    ctrl_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_STG-1:0] dec_stall;

    stall_decode u_stall_decode (
        .req_if     (req_if),
        .req_id     (req_id),
        .req_ex     (req_ex),
        .req_mem    (req_mem),
        .stall_mask (dec_stall)
    );

    // Next-state, redirect target latch and per-cycle stall/flush outputs.
    always_comb begin
        state_d            = state_q;
        tgt_d              = tgt_q;
        stall              = STALL_NONE;
        flush              = STALL_NONE;
        pc_redirect_valid  = 1'b0;
        pc_redirect_target = tgt_q;
        fetch_discard      = 1'b0;

        case (state_q)
            RUN: begin
                if (exc_valid) begin
                    // Exception overrides all stall requests and squashes younger stages.
                    flush              = FLUSH_ALL;
                    tgt_d              = exc_target;
                    pc_redirect_target = exc_target;
                    if (if_busy) begin
                        state_d = DRAIN;
                    end else begin
                        pc_redirect_valid = 1'b1;
                    end
                end else begin
                    stall = dec_stall;
                end
            end
            DRAIN: begin
                // Hold the PC and throw away the in-flight fetch until the bus goes idle.
                stall         = STALL_PC;
                flush         = FLUSH_ALL;
                fetch_discard = 1'b1;
                if (!if_busy) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                flush             = FLUSH_ALL;
                pc_redirect_valid = 1'b1;
                state_d           = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            stall             = STALL_NONE;
            flush             = FLUSH_ALL;
            pc_redirect_valid = 1'b0;
            fetch_discard     = 1'b0;
        end
    end

    // Count every cycle in which the pipeline is held or draining; wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if ((stall != STALL_NONE) || (state_q == DRAIN)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, target and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule
